// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//
// Shared definitions for the stopwatch sequencing controller.
//   mode_e     : run / paused / adjust operating mode encoding
//   SEL_SEC    : field select value for the seconds field
//   SEL_MIN    : field select value for the minutes field
//   cnt_width  : counter width needed to hold 0..n-1 (never narrower than 1)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'b00,
        MODE_PAUSED = 2'b01,
        MODE_ADJUST = 2'b10
    } mode_e;

    localparam logic SEL_SEC = 1'b0;
    localparam logic SEL_MIN = 1'b1;

    // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Conditions one raw mechanical button into a single-cycle press strobe.
// The raw level is synchronized through two flops; a candidate level must stay
// different from the accepted level for DB_CYCLES consecutive cycles before it
// is accepted. Accepting a 0->1 change emits one press pulse; accepting a 1->0
// change (release) emits nothing.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   btn   : raw asynchronous button level
//   press : registered one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module sw_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = cnt_width(DB_CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                // Any return to the accepted level restarts the stability window.
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
                level      <= sync_b;
                stable_cnt <= '0;
                press      <= sync_b;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Sequencing controller for the MM:SS stopwatch counter chain. Turns the raw
// pause/clear buttons and adj/sel switches into a run/paused/adjust mode,
// divides the system clock into run ticks (TICK_DIV) and adjust ticks
// (ADJ_DIV), and issues single-cycle increment/clear commands plus display
// blink control to a plain enable-driven BCD counter datapath.
//
// Parameters:
//   TICK_DIV  : clk cycles per run tick (>= 2)
//   ADJ_DIV   : clk cycles per adjust tick (>= 2)
//   DB_CYCLES : cycles a button level must be stable before acceptance (>= 1)
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset, synchronous release
//   pause_btn : raw button, each press toggles run/pause
//   clr_btn   : raw button, each press clears time to 00:00
//   adj       : switch, 1 = adjust mode
//   sel       : switch, 0 = seconds field, 1 = minutes field
//   sec_inc   : pulse, advance seconds field
//   min_inc   : pulse, advance minutes field only
//   carry_en  : 1 = seconds 59->00 carries into minutes
//   clr       : pulse, load 00:00
//   blink     : blanking phase for the selected field (0 outside adjust)
//   blink_sel : synchronized sel, field the display blinks
//   running   : 1 while in MODE_RUN
//
// Output protocol: sec_inc, min_inc and clr are registered single-cycle
// strobes with no back-pressure; the datapath must act on every cycle in which
// one is high. At most one of them is high in any cycle, and clr always wins
// over an increment scheduled for the same cycle.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pause_btn,
    input  logic clr_btn,
    input  logic adj,
    input  logic sel,
    output logic sec_inc,
    output logic min_inc,
    output logic carry_en,
    output logic clr,
    output logic blink,
    output logic blink_sel,
    output logic running
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam int AW = cnt_width(ADJ_DIV);

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------
    logic adj_meta;
    logic adj_s;
    logic sel_meta;
    logic sel_s;
    logic pause_press;
    logic clr_press;

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_pause_db (
        .clk   (clk),
        .reset (reset),
        .btn   (pause_btn),
        .press (pause_press)
    );

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_clr_db (
        .clk   (clk),
        .reset (reset),
        .btn   (clr_btn),
        .press (clr_press)
    );

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    mode_e         mode;
    mode_e         mode_next;
    logic          run_flag;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;

    logic [TW-1:0] tick_nxt;
    logic [AW-1:0] adj_nxt;
    logic          blink_nxt;
    logic          sec_nxt;
    logic          min_nxt;
    logic          clr_nxt;
    logic          entering_adj;
    logic          leaving_adj;

    // ---------------------------------------------------------------------
    // Next-state / output decode
    // ---------------------------------------------------------------------
    always_comb begin
        mode_next    = adj_s ? MODE_ADJUST : (run_flag ? MODE_RUN : MODE_PAUSED);
        entering_adj = (mode_next == MODE_ADJUST) && (mode != MODE_ADJUST);
        leaving_adj  = (mode == MODE_ADJUST) && (mode_next != MODE_ADJUST);

        tick_nxt  = tick_cnt;
        adj_nxt   = adj_cnt;
        blink_nxt = blink;
        sec_nxt   = 1'b0;
        min_nxt   = 1'b0;
        clr_nxt   = 1'b0;

        unique case (mode)
            MODE_RUN: begin
                if (tick_cnt == TW'(TICK_DIV - 1)) begin
                    tick_nxt = '0;
                    sec_nxt  = 1'b1;
                end else begin
                    tick_nxt = tick_cnt + 1'b1;
                end
            end
            MODE_PAUSED: begin
                // tick_cnt holds so the partial second survives the pause.
            end
            MODE_ADJUST: begin
                tick_nxt = '0;
                if (adj_cnt == AW'(ADJ_DIV - 1)) begin
                    adj_nxt   = '0;
                    blink_nxt = ~blink;
                    if (sel_s == SEL_MIN) begin
                        min_nxt = 1'b1;
                    end else begin
                        sec_nxt = 1'b1;
                    end
                end else begin
                    adj_nxt = adj_cnt + 1'b1;
                end
            end
            default: begin
                tick_nxt = '0;
                adj_nxt  = '0;
            end
        endcase

        if (entering_adj) begin
            adj_nxt   = '0;
            blink_nxt = 1'b1;
        end

        // Restarting tick_cnt here makes the first run tick a full TICK_DIV
        // after the mode leaves adjust.
        if (leaving_adj) begin
            adj_nxt   = '0;
            blink_nxt = 1'b0;
            tick_nxt  = '0;
        end

        if (clr_press) begin
            clr_nxt  = 1'b1;
            tick_nxt = '0;
            adj_nxt  = '0;
            sec_nxt  = 1'b0;
            min_nxt  = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adj_meta  <= 1'b0;
            adj_s     <= 1'b0;
            sel_meta  <= 1'b0;
            sel_s     <= 1'b0;
            mode      <= MODE_RUN;
            run_flag  <= 1'b1;
            tick_cnt  <= '0;
            adj_cnt   <= '0;
            sec_inc   <= 1'b0;
            min_inc   <= 1'b0;
            clr       <= 1'b0;
            blink     <= 1'b0;
            blink_sel <= SEL_SEC;
            carry_en  <= 1'b1;
            running   <= 1'b1;
        end else begin
            adj_meta  <= adj;
            adj_s     <= adj_meta;
            sel_meta  <= sel;
            sel_s     <= sel_meta;
            // Pause toggles in every mode, including adjust.
            run_flag  <= run_flag ^ pause_press;
            mode      <= mode_next;
            tick_cnt  <= tick_nxt;
            adj_cnt   <= adj_nxt;
            sec_inc   <= sec_nxt;
            min_inc   <= min_nxt;
            clr       <= clr_nxt;
            blink     <= blink_nxt;
            blink_sel <= sel_s;
            // Level outputs are registered from mode_next so they change on
            // the same edge as mode itself.
            carry_en  <= (mode_next != MODE_ADJUST);
            running   <= (mode_next == MODE_RUN);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl at TICK_DIV=10, ADJ_DIV=4, DB_CYCLES=3.
// cyc counts rising edges since reset release (first edge = 1); inputs are
// driven and outputs sampled on falling edges. Every pulse on sec_inc,
// min_inc or clr is matched against a queue of hand-computed expected events
// {cycle, clr, min_inc, sec_inc, carry_en, blink}.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int ADJ_DIV   = 4;
    localparam int DB_CYCLES = 3;
    localparam int W         = 21;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic pause_btn = 1'b0;
    logic clr_btn   = 1'b0;
    logic adj       = 1'b0;
    logic sel       = 1'b0;
    logic sec_inc;
    logic min_inc;
    logic carry_en;
    logic clr;
    logic blink;
    logic blink_sel;
    logic running;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .ADJ_DIV   (ADJ_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pause_btn (pause_btn),
        .clr_btn   (clr_btn),
        .adj       (adj),
        .sel       (sel),
        .sec_inc   (sec_inc),
        .min_inc   (min_inc),
        .carry_en  (carry_en),
        .clr       (clr),
        .blink     (blink),
        .blink_sel (blink_sel),
        .running   (running)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required bench to finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input int c, input logic e_clr, input logic e_min,
                                        input logic e_sec, input logic e_carry, input logic e_blink);
        return {16'(c), e_clr, e_min, e_sec, e_carry, e_blink};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h required %0h", name, cyc, got, want);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        pause_btn = 1'b0;
        clr_btn   = 1'b0;
        adj       = 1'b0;
        sel       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic end_scenario(input string name);
        check({name, "_pending_events"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && (sec_inc || min_inc || clr)) begin
            mon_got = ev(cyc, clr, min_inc, sec_inc, carry_en, blink);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: got cyc=%0d clr,min,sec,carry,blink=%b, required no pulse",
                         mon_got[20:5], mon_got[4:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pulse_event: got cyc=%0d clr,min,sec,carry,blink=%b, required cyc=%0d %b",
                             mon_got[20:5], mon_got[4:0], mon_exp[20:5], mon_exp[4:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset and run
        repeat (3) @(negedge clk);
        check("reset_outputs", {sec_inc, min_inc, clr, blink, blink_sel, carry_en, running}, 7'b0000011);
        reset = 1'b1;
        exp_q.push_back(ev(10, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(20, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(30, 0, 0, 1, 1, 0));
        wait_until(35);
        check("run_running", running, 1);
        check("run_carry_en", carry_en, 1);
        end_scenario("run");

        // Pause at frozen tick_cnt = 6, then resume
        do_reset();
        exp_q.push_back(ev(10, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(71, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(81, 0, 0, 1, 1, 0));
        wait_until(9);  pause_btn = 1'b1;
        wait_until(15); check("pause_running_before", running, 1);
        wait_until(16); check("pause_running_after", running, 0);
        wait_until(30); pause_btn = 1'b0;
        wait_until(59); check("pause_held", running, 0);
        wait_until(60); pause_btn = 1'b1;
        wait_until(66); check("resume_running_before", running, 0);
        wait_until(67); check("resume_running_after", running, 1);
        wait_until(75); pause_btn = 1'b0;
        wait_until(85); check("resume_running_end", running, 1);
        end_scenario("pause");

        // Adjust minutes, then leave adjust
        do_reset();
        adj = 1'b1;
        sel = 1'b1;
        exp_q.push_back(ev(7,  0, 1, 0, 0, 0));
        exp_q.push_back(ev(11, 0, 1, 0, 0, 1));
        exp_q.push_back(ev(15, 0, 1, 0, 0, 0));
        exp_q.push_back(ev(19, 0, 1, 0, 0, 1));
        exp_q.push_back(ev(32, 0, 0, 1, 1, 0));
        wait_until(2);
        check("adj_early_blink_sel", blink_sel, 0);
        check("adj_early_blink", blink, 0);
        check("adj_early_carry_en", carry_en, 1);
        wait_until(3);
        check("adj_blink_sel", blink_sel, 1);
        check("adj_enter_blink", blink, 1);
        check("adj_carry_en", carry_en, 0);
        check("adj_running", running, 0);
        wait_until(19); adj = 1'b0;
        wait_until(21);
        check("adj_exit_blink_before", blink, 1);
        check("adj_exit_carry_before", carry_en, 0);
        wait_until(22);
        check("adj_exit_blink_after", blink, 0);
        check("adj_exit_carry_after", carry_en, 1);
        check("adj_exit_running", running, 1);
        wait_until(35); sel = 1'b0;
        end_scenario("adjust");

        // Debounce: glitches then a held press; lone 2-cycle glitch later
        do_reset();
        exp_q.push_back(ev(10, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(15, 1, 0, 0, 1, 0));
        exp_q.push_back(ev(25, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(35, 0, 0, 1, 1, 0));
        wait_until(2);  clr_btn = 1'b1;
        wait_until(3);  clr_btn = 1'b0;
        wait_until(5);  clr_btn = 1'b1;
        wait_until(7);  clr_btn = 1'b0;
        wait_until(9);  clr_btn = 1'b1;
        wait_until(16); clr_btn = 1'b0;
        wait_until(30); clr_btn = 1'b1;
        wait_until(32); clr_btn = 1'b0;
        wait_until(40);
        end_scenario("debounce");

        // Clear colliding with a run tick; then simultaneous pause + clear
        do_reset();
        exp_q.push_back(ev(10, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(20, 1, 0, 0, 1, 0));
        exp_q.push_back(ev(30, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(40, 0, 0, 1, 1, 0));
        exp_q.push_back(ev(41, 1, 0, 0, 1, 0));
        wait_until(14); clr_btn = 1'b1;
        wait_until(20); clr_btn = 1'b0;
        wait_until(35); clr_btn = 1'b1; pause_btn = 1'b1;
        wait_until(41); check("both_running_before", running, 1);
        wait_until(42); check("both_running_after", running, 0);
        clr_btn = 1'b0; pause_btn = 1'b0;
        wait_until(60);
        end_scenario("clear");

        // Asynchronous reset while in adjust with blink = 1
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        exp_q.push_back(ev(7,  0, 0, 1, 0, 0));
        exp_q.push_back(ev(11, 0, 0, 1, 0, 1));
        wait_until(12);
        check("areset_pre_blink", blink, 1);
        check("areset_pre_carry", carry_en, 0);
        #2;
        reset = 1'b0;
        #1;
        check("areset_outputs", {sec_inc, min_inc, clr, blink, blink_sel, carry_en, running}, 7'b0000011);
        adj = 1'b0;
        end_scenario("areset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
